rom_port_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer that shares one port of the dual-ported sprite/maze ROM between `NREQ` requesters, such as the VGA pixel fetcher and the maze collision checker. Each requester posts a base address and a burst length. The block grants one requester at a time and drives the ROM enable and address for `len` consecutive words. It then steers the returned ROM data back to the owner with a one-hot valid.

---
 rtl/rom_port_arbiter.sv | 116 +++++++++++
 tb/tb_rom_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one ROM port among NREQ requesters.
// Read data is steered back to the burst owner one cycle after each issued beat.
module rom_port_arbiter #(
   parameter int NREQ  = 2,
   parameter int ASIZE = 11,
   parameter int WIDTH = 16,
   parameter int LSIZE = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*ASIZE-1:0] req_addr,
   input  logic [NREQ*LSIZE-1:0] req_len,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  rom_en,
   output logic [ASIZE-1:0]      rom_addr,
   input  logic [WIDTH-1:0]      rom_dout,
   output logic [NREQ-1:0]       rvalid,
   output logic                  rlast,
   output logic [WIDTH-1:0]      rdata
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    owner;
   logic [PW-1:0]    win;
   logic             found;
   logic [ASIZE-1:0] addr;
   logic [LSIZE-1:0] cnt;
   logic [ASIZE-1:0] win_addr;
   logic [LSIZE-1:0] win_len;
   logic [LSIZE-1:0] len_eff;
   logic             start;
   logic             last;

   function automatic logic [PW-1:0] wrap_idx(input int v);
      int r;
      r = v;
      if (r >= NREQ) r = r - NREQ;
      return PW'(r);
   endfunction

   // First requesting index at or above ptr, wrapping
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[wrap_idx(int'(ptr) + i)]) begin
            found = 1'b1;
            win   = wrap_idx(int'(ptr) + i);
         end
      end
   end

   assign win_addr = req_addr[win*ASIZE +: ASIZE];
   assign win_len  = req_len[win*LSIZE +: LSIZE];
   assign len_eff  = (win_len == '0) ? LSIZE'(1) : win_len;
   assign start    = (state == IDLE) && found;
   assign last     = (state == BURST) && (cnt == LSIZE'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (found) state_nx = BURST;
         BURST: if (cnt == LSIZE'(1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= '0;
         owner  <= '0;
         addr   <= '0;
         cnt    <= '0;
         gnt    <= '0;
         rvalid <= '0;
         rlast  <= 1'b0;
      end else begin
         gnt <= '0;
         if (start) begin
            owner <= win;
            addr  <= win_addr;
            cnt   <= len_eff;
            gnt   <= NREQ'(1) << win;
            ptr   <= (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
         end else if (state == BURST) begin
            addr <= addr + ASIZE'(1);
            cnt  <= cnt - LSIZE'(1);
         end
         // Return pipeline: tags each beat with its owner as the ROM data lands
         rvalid <= rom_en ? (NREQ'(1) << owner) : '0;
         rlast  <= last;
      end
   end

   assign busy     = (state == BURST);
   assign rom_en   = busy;
   assign rom_addr = addr;
   assign rdata    = rom_dout;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a 1-cycle synchronous ROM model.
// ROM word at address a is a ^ 16'hA5A5.
module tb_rom_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [10:0] a0, a1;
   logic [4:0]  l0, l1;
   logic [1:0]  gnt;
   logic        busy;
   logic        rom_en;
   logic [10:0] rom_addr;
   logic [15:0] rom_dout;
   logic [1:0]  rvalid;
   logic        rlast;
   logic [15:0] rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rom_port_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_addr ({a1, a0}),
      .req_len  ({l1, l0}),
      .gnt      (gnt),
      .busy     (busy),
      .rom_en   (rom_en),
      .rom_addr (rom_addr),
      .rom_dout (rom_dout),
      .rvalid   (rvalid),
      .rlast    (rlast),
      .rdata    (rdata)
   );

   always @(posedge clk)
      if (rom_en) rom_dout <= {5'b0, rom_addr} ^ 16'hA5A5;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      int b, p, own;
      logic [10:0] base;
      rst = 1'b1;
      req = 2'b00;
      a0 = '0; a1 = '0; l0 = '0; l1 = '0;
      rom_dout = '0;
      tick();
      tick();
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_en", rom_en, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      rst = 1'b0;
      tick();

      // single beat
      a0 = 11'h010; l0 = 5'd1; req = 2'b01;
      tick();
      check("sb_gnt", gnt, 2'b01);
      check("sb_en", rom_en, 1);
      check("sb_addr", rom_addr, 11'h010);
      check("sb_busy", busy, 1);
      req = 2'b00;
      tick();
      check("sb_rvalid", rvalid, 2'b01);
      check("sb_rlast", rlast, 1);
      check("sb_rdata", rdata, 16'hA5B5);
      check("sb_en_off", rom_en, 0);
      check("sb_busy_off", busy, 0);
      tick();
      check("sb_rvalid_off", rvalid, 0);

      // contention, both held high, len=2
      do_reset();
      a0 = 11'h100; a1 = 11'h200; l0 = 5'd2; l1 = 5'd2; req = 2'b11;
      for (int c = 1; c <= 12; c++) begin
         tick();
         b = (c - 1) / 3;
         p = (c - 1) % 3;
         own = b % 2;
         base = (own == 1) ? 11'h200 : 11'h100;
         check("ct_gnt", gnt, (p == 0) ? (32'd1 << own) : 0);
         check("ct_en", rom_en, (p != 2) ? 1 : 0);
         if (p != 2) check("ct_addr", rom_addr, base + 11'(p));
         check("ct_rvalid", rvalid, (p == 0) ? 0 : (32'd1 << own));
         check("ct_rlast", rlast, (p == 2) ? 1 : 0);
         if (c == 12) req = 2'b00;
      end
      tick();
      check("ct_idle", busy, 0);

      // address wrap
      a0 = 11'h7FE; l0 = 5'd4; req = 2'b01;
      tick();
      check("wr_gnt", gnt, 2'b01);
      check("wr_a0", rom_addr, 11'h7FE);
      req = 2'b00;
      tick();
      check("wr_a1", rom_addr, 11'h7FF);
      check("wr_v0", rvalid, 2'b01);
      check("wr_d0", rdata, 16'hA25B);
      check("wr_l0", rlast, 0);
      tick();
      check("wr_a2", rom_addr, 11'h000);
      check("wr_d1", rdata, 16'hA25A);
      check("wr_l1", rlast, 0);
      tick();
      check("wr_a3", rom_addr, 11'h001);
      check("wr_en3", rom_en, 1);
      check("wr_d2", rdata, 16'hA5A5);
      check("wr_l2", rlast, 0);
      tick();
      check("wr_en_off", rom_en, 0);
      check("wr_v3", rvalid, 2'b01);
      check("wr_d3", rdata, 16'hA5A4);
      check("wr_l3", rlast, 1);
      tick();
      check("wr_v_off", rvalid, 0);

      // zero length acts as one beat
      a1 = 11'h033; l1 = 5'd0; req = 2'b10;
      tick();
      check("zl_gnt", gnt, 2'b10);
      check("zl_addr", rom_addr, 11'h033);
      req = 2'b00;
      tick();
      check("zl_rvalid", rvalid, 2'b10);
      check("zl_rlast", rlast, 1);
      check("zl_rdata", rdata, 16'hA596);
      check("zl_busy", busy, 0);
      tick();
      check("zl_rvalid_off", rvalid, 0);

      // reset mid-burst
      a0 = 11'h040; l0 = 5'd8; req = 2'b01;
      tick();
      check("rm_gnt", gnt, 2'b01);
      req = 2'b00;
      tick();
      tick();
      check("rm_addr2", rom_addr, 11'h042);
      rst = 1'b1;
      #1;
      check("rm_busy", busy, 0);
      check("rm_en", rom_en, 0);
      check("rm_addr", rom_addr, 0);
      check("rm_rvalid", rvalid, 0);
      check("rm_rlast", rlast, 0);
      tick();
      rst = 1'b0;
      tick();
      check("rm_no_rvalid", rvalid, 0);

      // ptr restarts at 0, then late requester 1
      a0 = 11'h050; l0 = 5'd2; a1 = 11'h060; l1 = 5'd1; req = 2'b11;
      tick();
      check("lt_gnt0", gnt, 2'b01);
      check("lt_addr0", rom_addr, 11'h050);
      req = 2'b01;
      tick();
      check("lt_addr1", rom_addr, 11'h051);
      req = 2'b11;
      tick();
      check("lt_idle_busy", busy, 0);
      check("lt_idle_gnt", gnt, 0);
      check("lt_idle_rlast", rlast, 1);
      tick();
      check("lt_gnt1", gnt, 2'b10);
      check("lt_addr_r1", rom_addr, 11'h060);
      req = 2'b00;
      tick();
      check("lt_rvalid1", rvalid, 2'b10);
      check("lt_rlast1", rlast, 1);
      check("lt_rdata1", rdata, 16'hA5C5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
